// File: rtl/uart_tx.sv
// UART transmit serializer: accepts a word over valid/ready and shifts out
// start, LSB-first data, optional parity and 1..2 stop bits on rising edges of the baud tick.
module uart_tx #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done
);

    // state  | meaning
    // IDLE   | line high, waiting for a word
    // ALIGN  | word latched, waiting for the next bit boundary
    // START  | driving the start bit
    // DATA   | driving data bits, LSB first
    // PARITY | driving the parity bit
    // STOP   | driving stop bits
    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

    state_t                 state;
    state_t                 state_next;
    logic                   tick_q;
    logic                   bit_edge;
    logic                   accept;
    logic [DATA_BITS-1:0]   shift;
    logic                   parity_bit;
    logic [2:0]             bit_cnt;
    logic                   stop_cnt;

    assign bit_edge = tick & ~tick_q;
    assign accept   = tx_valid & tx_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) state_next = S_ALIGN;
            end
            S_ALIGN: begin
                if (bit_edge) state_next = S_START;
            end
            S_START: begin
                if (bit_edge) state_next = S_DATA;
            end
            S_DATA: begin
                if (bit_edge && bit_cnt == LAST_BIT)
                    state_next = (PARITY != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (bit_edge) state_next = S_STOP;
            end
            S_STOP: begin
                if (bit_edge && stop_cnt == 1'b0) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        tx_ready = (state == S_IDLE);
        busy     = (state != S_IDLE);
    end

    // tick_q resets high so a tick already high at reset release is not an edge
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q     <= 1'b1;
            tx         <= 1'b1;
            shift      <= '0;
            parity_bit <= 1'b0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            tick_q     <= tick;
            frame_done <= 1'b0;
            if (accept) begin
                shift      <= tx_data;
                parity_bit <= (PARITY == 2) ? ~^tx_data : ^tx_data;
            end
            if (bit_edge) begin
                case (state)
                    S_ALIGN: tx <= 1'b0;
                    S_START: begin
                        tx      <= shift[0];
                        bit_cnt <= '0;
                    end
                    S_DATA: begin
                        if (bit_cnt != LAST_BIT) begin
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                            bit_cnt <= bit_cnt + 3'd1;
                        end else if (PARITY != 0) begin
                            tx <= parity_bit;
                        end else begin
                            tx       <= 1'b1;
                            stop_cnt <= STOP_LAST;
                        end
                    end
                    S_PARITY: begin
                        tx       <= 1'b1;
                        stop_cnt <= STOP_LAST;
                    end
                    S_STOP: begin
                        if (stop_cnt == 1'b0) frame_done <= 1'b1;
                        else                  stop_cnt   <= stop_cnt - 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: 8N1, 8E1 and 8O2 instances share clock, reset and tick.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick = 1'b0;
    logic [7:0] tx_data;
    logic       valid_n, valid_e, valid_o;
    logic       ready_n, ready_e, ready_o;
    logic       tx_n, tx_e, tx_o;
    logic       busy_n, busy_e, busy_o;
    logic       fd_n, fd_e, fd_o;

    int tests_run;
    int tests_failed;
    int tick_mode = 0;   // 0 run, 1 hold low, 2 hold high
    int tcnt = 0;
    int fdc_n = 0, fdc_e = 0, fdc_o = 0, bc_n = 0;

    uart_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_n (
        .clk(clk), .reset(reset), .tick(tick), .tx_data(tx_data), .tx_valid(valid_n),
        .tx_ready(ready_n), .tx(tx_n), .busy(busy_n), .frame_done(fd_n));
    uart_tx #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut_e (
        .clk(clk), .reset(reset), .tick(tick), .tx_data(tx_data), .tx_valid(valid_e),
        .tx_ready(ready_e), .tx(tx_e), .busy(busy_e), .frame_done(fd_e));
    uart_tx #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) dut_o (
        .clk(clk), .reset(reset), .tick(tick), .tx_data(tx_data), .tx_valid(valid_o),
        .tx_ready(ready_o), .tx(tx_o), .busy(busy_o), .frame_done(fd_o));

    always #5 clk = ~clk;

    // baud square wave: 8 clk period, 4 low then 4 high
    always @(negedge clk) begin
        if (tick_mode == 0) begin
            tick = (tcnt >= 4);
            tcnt = (tcnt + 1) % 8;
        end else if (tick_mode == 1) begin
            tick = 1'b0;
            tcnt = 0;
        end else begin
            tick = 1'b1;
            tcnt = 0;
        end
    end

    always @(negedge clk) begin
        if (fd_n === 1'b1) fdc_n++;
        if (fd_e === 1'b1) fdc_e++;
        if (fd_o === 1'b1) fdc_o++;
        if (busy_n === 1'b1) bc_n++;
    end

    function automatic logic get_tx(input int sel);
        case (sel)
            0:       return tx_n;
            1:       return tx_e;
            default: return tx_o;
        endcase
    endfunction

    function automatic logic get_ready(input int sel);
        case (sel)
            0:       return ready_n;
            1:       return ready_e;
            default: return ready_o;
        endcase
    endfunction

    function automatic logic get_fd(input int sel);
        case (sel)
            0:       return fd_n;
            1:       return fd_e;
            default: return fd_o;
        endcase
    endfunction

    task automatic send(input int sel, input logic [7:0] d, output bit ok);
        int n;
        n = 0;
        while (get_ready(sel) !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        tx_data = d;
        case (sel)
            0:       valid_n = 1'b1;
            1:       valid_e = 1'b1;
            default: valid_o = 1'b1;
        endcase
        @(negedge clk);
        valid_n = 1'b0;
        valid_e = 1'b0;
        valid_o = 1'b0;
        ok = (n < 50);
    endtask

    task automatic wait_start(input int sel, input int limit, output int waited);
        waited = 0;
        while (get_tx(sel) !== 1'b0 && waited < limit) begin
            @(negedge clk);
            waited++;
        end
    endtask

    // starts on the first negedge of a bit; returns on the last negedge of bit n-1
    task automatic read_bits(input int sel, input int n, output logic [11:0] bits,
                             output bit stable);
        logic v;
        bits   = '0;
        stable = 1'b1;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 8; j++) begin
                if (i != 0 || j != 0) @(negedge clk);
                v = get_tx(sel);
                if (j == 0) bits[i] = v;
                else if (v !== bits[i]) stable = 1'b0;
            end
        end
    endtask

    // counts cycles of high line until frame_done; returns on the frame_done negedge
    task automatic stop_high(input int sel, output int high, output bit clean);
        bit seen;
        high  = 0;
        clean = 1'b1;
        seen  = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (get_fd(sel) === 1'b1) seen = 1'b1;
            else begin
                if (get_tx(sel) !== 1'b1) clean = 1'b0;
                high++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (4) @(negedge clk);
        tests_run++;
        if (tx_n !== 1'b1 || tx_e !== 1'b1 || tx_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_tx: got %b%b%b expected 111", tx_n, tx_e, tx_o);
        end
        tests_run++;
        if (ready_n !== 1'b1 || busy_n !== 1'b0 || fd_n !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: ready=%b busy=%b fd=%b expected 1 0 0",
                     ready_n, busy_n, fd_n);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (tx_n !== 1'b1 || ready_n !== 1'b1 || busy_e !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_idle: tx=%b ready=%b busy_e=%b expected 1 1 0",
                     tx_n, ready_n, busy_e);
        end
    endtask

    task automatic test_tick_high_at_reset();
        tick_mode = 2;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        tests_run++;
        if (tx_n !== 1'b1 || tx_e !== 1'b1 || tx_o !== 1'b1 || busy_n !== 1'b0
            || ready_n !== 1'b1) begin
            tests_failed++;
            $display("FAIL tick_high_idle: tx=%b%b%b busy=%b ready=%b expected 111 0 1",
                     tx_n, tx_e, tx_o, busy_n, ready_n);
        end
        tick_mode = 0;
        repeat (16) @(negedge clk);
    endtask

    task automatic test_8n1();
        int waited, high, bc0, fc0;
        logic [11:0] bits;
        bit stable, ok, clean;
        bc0 = bc_n;
        fc0 = fdc_n;
        send(0, 8'hA5, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL 8n1_accept: ready never seen, expected ready");
        end
        wait_start(0, 20, waited);
        tests_run++;
        if (waited < 1 || waited > 8) begin
            tests_failed++;
            $display("FAIL 8n1_latency: got %0d clk expected 1..8", waited);
        end
        tests_run++;
        if (ready_n !== 1'b0 || busy_n !== 1'b1) begin
            tests_failed++;
            $display("FAIL 8n1_in_frame: ready=%b busy=%b expected 0 1", ready_n, busy_n);
        end
        read_bits(0, 9, bits, stable);
        tests_run++;
        if (bits !== 12'h14A || !stable) begin
            tests_failed++;
            $display("FAIL 8n1_bits: got %h stable=%b expected 14a stable=1", bits, stable);
        end
        stop_high(0, high, clean);
        tests_run++;
        if (high != 8 || !clean) begin
            tests_failed++;
            $display("FAIL 8n1_stop: got %0d clk clean=%b expected 8 clean=1", high, clean);
        end
        tests_run++;
        if (ready_n !== 1'b1 || busy_n !== 1'b0) begin
            tests_failed++;
            $display("FAIL 8n1_done_cycle: ready=%b busy=%b expected 1 0", ready_n, busy_n);
        end
        @(negedge clk);
        tests_run++;
        if (fdc_n - fc0 != 1) begin
            tests_failed++;
            $display("FAIL 8n1_frame_done: got %0d pulse cycles expected 1", fdc_n - fc0);
        end
        tests_run++;
        if (bc_n - bc0 != waited + 80) begin
            tests_failed++;
            $display("FAIL 8n1_busy_len: got %0d expected %0d", bc_n - bc0, waited + 80);
        end
    endtask

    task automatic test_parity();
        int waited, high, fc0;
        logic [11:0] bits;
        bit stable, ok, clean;
        fc0 = fdc_e;
        send(1, 8'h07, ok);
        wait_start(1, 20, waited);
        read_bits(1, 10, bits, stable);
        tests_run++;
        if (bits !== 12'h20E || !stable || !ok) begin
            tests_failed++;
            $display("FAIL even_bits: got %h stable=%b expected 20e stable=1", bits, stable);
        end
        stop_high(1, high, clean);
        @(negedge clk);
        tests_run++;
        if (high != 8 || !clean || fdc_e - fc0 != 1) begin
            tests_failed++;
            $display("FAIL even_stop: got %0d clk, %0d done expected 8 clk, 1 done",
                     high, fdc_e - fc0);
        end

        fc0 = fdc_o;
        send(2, 8'h07, ok);
        wait_start(2, 20, waited);
        read_bits(2, 10, bits, stable);
        tests_run++;
        if (bits !== 12'h00E || !stable || !ok) begin
            tests_failed++;
            $display("FAIL odd_bits: got %h stable=%b expected 00e stable=1", bits, stable);
        end
        stop_high(2, high, clean);
        @(negedge clk);
        tests_run++;
        if (high != 16 || !clean || fdc_o - fc0 != 1) begin
            tests_failed++;
            $display("FAIL odd_two_stop: got %0d clk, %0d done expected 16 clk, 1 done",
                     high, fdc_o - fc0);
        end
    endtask

    task automatic test_back_to_back();
        int waited, high, fc0, n;
        logic [11:0] bits;
        logic [11:0] exp;
        bit stable, clean;
        fc0 = fdc_n;
        n = 0;
        while (ready_n !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        tx_data = 8'h01;
        valid_n = 1'b1;
        @(negedge clk);
        tx_data = 8'h02;
        for (int k = 0; k < 3; k++) begin
            wait_start(0, 20, waited);
            if (k != 0) begin
                tests_run++;
                if (waited + 1 != 8) begin
                    tests_failed++;
                    $display("FAIL b2b_gap%0d: got %0d clk after done expected 8",
                             k, waited + 1);
                end
            end
            tests_run++;
            if (ready_n !== 1'b0) begin
                tests_failed++;
                $display("FAIL b2b_ready%0d: got %b expected 0", k, ready_n);
            end
            read_bits(0, 9, bits, stable);
            exp = {3'b000, 8'(k + 1), 1'b0};
            tests_run++;
            if (bits !== exp || !stable) begin
                tests_failed++;
                $display("FAIL b2b_bits%0d: got %h expected %h", k, bits, exp);
            end
            stop_high(0, high, clean);
            if (k == 2) begin
                valid_n = 1'b0;
            end else begin
                @(negedge clk);
                tx_data = 8'(k + 3);
            end
        end
        @(negedge clk);
        tests_run++;
        if (fdc_n - fc0 != 3) begin
            tests_failed++;
            $display("FAIL b2b_frames: got %0d done pulses expected 3", fdc_n - fc0);
        end
        repeat (40) @(negedge clk);
        tests_run++;
        if (busy_n !== 1'b0 || tx_n !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_no_extra: busy=%b tx=%b expected 0 1", busy_n, tx_n);
        end
    endtask

    task automatic test_reset_mid_frame();
        int waited, high, fc0;
        logic [11:0] bits;
        bit stable, ok, clean;
        fc0 = fdc_n;
        send(0, 8'h55, ok);
        wait_start(0, 20, waited);
        read_bits(0, 4, bits, stable);
        repeat (2) @(negedge clk);
        tests_run++;
        if (bits !== 12'h00A || tx_n !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_prefix: got %h bit3=%b expected 00a bit3=0", bits, tx_n);
        end
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if (tx_n !== 1'b1 || ready_n !== 1'b1 || busy_n !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset: tx=%b ready=%b busy=%b expected 1 1 0",
                     tx_n, ready_n, busy_n);
        end
        reset = 1'b0;
        repeat (30) @(negedge clk);
        tests_run++;
        if (fdc_n - fc0 != 0) begin
            tests_failed++;
            $display("FAIL mid_no_done: got %0d done pulses expected 0", fdc_n - fc0);
        end
        send(0, 8'h3C, ok);
        wait_start(0, 20, waited);
        read_bits(0, 9, bits, stable);
        tests_run++;
        if (bits !== 12'h078 || !stable) begin
            tests_failed++;
            $display("FAIL mid_next_bits: got %h expected 078", bits);
        end
        stop_high(0, high, clean);
        @(negedge clk);
        tests_run++;
        if (high != 8 || fdc_n - fc0 != 1) begin
            tests_failed++;
            $display("FAIL mid_next_done: got %0d clk, %0d done expected 8, 1",
                     high, fdc_n - fc0);
        end
    endtask

    task automatic test_tick_stall();
        int waited, high, fc0, bad;
        logic [11:0] bits;
        bit stable, ok, clean;
        fc0 = fdc_n;
        send(0, 8'hC3, ok);
        wait_start(0, 20, waited);
        read_bits(0, 2, bits, stable);
        tests_run++;
        if (bits !== 12'h002 || !stable) begin
            tests_failed++;
            $display("FAIL stall_prefix: got %h expected 002", bits);
        end
        repeat (3) @(negedge clk);
        tick_mode = 1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx_n !== 1'b1 || busy_n !== 1'b1) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL stall_hold: got %0d moved cycles expected 0", bad);
        end
        tick_mode = 0;
        wait_start(0, 40, waited);
        read_bits(0, 6, bits, stable);
        tests_run++;
        if (bits !== 12'h030 || !stable) begin
            tests_failed++;
            $display("FAIL stall_rest: got %h stable=%b expected 030 stable=1", bits, stable);
        end
        stop_high(0, high, clean);
        @(negedge clk);
        tests_run++;
        if (high != 8 || fdc_n - fc0 != 1) begin
            tests_failed++;
            $display("FAIL stall_done: got %0d clk, %0d done expected 8, 1",
                     high, fdc_n - fc0);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        valid_n      = 1'b0;
        valid_e      = 1'b0;
        valid_o      = 1'b0;
        tx_data      = 8'h00;
        @(negedge clk);
        test_reset();
        test_tick_high_at_reset();
        test_8n1();
        test_parity();
        test_back_to_back();
        test_reset_mid_frame();
        test_tick_stall();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
